// File: rtl/matrix_scan_driver_if.sv
// ----------------------------------------------------------------------------
// matrix_scan_driver_if
//
// Bundles the game-state inputs and matrix-pin outputs of matrix_scan_driver.
//   bird_grid    [15:0][15:0]  one-hot bird grid, [r] is matrix row r (0 = top)
//   pipe_grid    [15:0][15:0]  pipe grid, same layout
//   clear_hit    1             synchronous clear of the sticky hit flag
//   row_sink     16            active-low one-hot row select
//   red_driver   16            column data for pipes
//   green_driver 16            column data for the bird
//   frame_done   1             pulse in the last cycle of each frame
//   bird_row     4             decoded bird row of the last completed frame
//   bird_valid   1             last completed frame had exactly one bird row
//   hit          1             sticky bird/pipe overlap flag
//
// master: the side producing the grids and consuming the matrix signals.
// slave : the scan driver itself.
// ----------------------------------------------------------------------------
interface matrix_scan_driver_if;
  logic [15:0][15:0] bird_grid;
  logic [15:0][15:0] pipe_grid;
  logic              clear_hit;
  logic [15:0]       row_sink;
  logic [15:0]       red_driver;
  logic [15:0]       green_driver;
  logic              frame_done;
  logic [3:0]        bird_row;
  logic              bird_valid;
  logic              hit;

  modport master (
    output bird_grid, pipe_grid, clear_hit,
    input  row_sink, red_driver, green_driver, frame_done,
           bird_row, bird_valid, hit
  );

  modport slave (
    input  bird_grid, pipe_grid, clear_hit,
    output row_sink, red_driver, green_driver, frame_done,
           bird_row, bird_valid, hit
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// ----------------------------------------------------------------------------
// matrix_scan_driver
//
// Row-multiplexed driver for a 16x16 red/green LED matrix. Each frame is
// 16 row slots of DWELL cycles; cycle 0 of a slot blanks the matrix, the
// remaining cycles drive one row. Both grids are snapshotted once per frame
// so mid-frame input changes never tear the picture. While scanning, the
// bird grid is decoded back to a row index and bird/pipe overlap sets a
// sticky hit flag.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    matrix_scan_driver_if.slave (grids, clear_hit, matrix outputs,
//          decoded bird row/valid, hit)
//
// Parameter:
//   DWELL  cycles per row slot (>= 2); slot cycle 0 is blanking.
// ----------------------------------------------------------------------------
module matrix_scan_driver #(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_scan_driver_if.slave   bus
);

  localparam int               DW_W    = $clog2(DWELL);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]  DW_ONE  = DW_W'(1);

  // Scan position
  logic [3:0]        row_cnt_q,   row_cnt_d;
  logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;

  // Per-frame snapshot of the input grids
  logic [15:0][15:0] bird_shadow_q, bird_shadow_d;
  logic [15:0][15:0] pipe_shadow_q, pipe_shadow_d;

  // Bird decode: number of nonzero rows seen (saturating at 2) and last one
  logic [1:0]        nz_cnt_q,    nz_cnt_d;
  logic [3:0]        rec_row_q,   rec_row_d;

  // Frame-level results
  logic [3:0]        bird_row_q,  bird_row_d;
  logic              bird_valid_q, bird_valid_d;
  logic              hit_q,       hit_d;

  // Scan-position decodes
  logic              frame_start;
  logic              frame_end;
  logic              blank;
  logic              decode_slot;
  logic [15:0]       cur_bird;
  logic [15:0]       cur_pipe;

  assign frame_start = (row_cnt_q == 4'd0)  && (dwell_cnt_q == '0);
  assign frame_end   = (row_cnt_q == 4'd15) && (dwell_cnt_q == DW_LAST);
  assign blank       = (dwell_cnt_q == '0);
  assign decode_slot = (dwell_cnt_q == DW_ONE);
  assign cur_bird    = bird_shadow_q[row_cnt_q];
  assign cur_pipe    = pipe_shadow_q[row_cnt_q];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_q     <= 4'd0;
      dwell_cnt_q   <= '0;
      bird_shadow_q <= '0;
      pipe_shadow_q <= '0;
      nz_cnt_q      <= 2'd0;
      rec_row_q     <= 4'd0;
      bird_row_q    <= 4'd0;
      bird_valid_q  <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      row_cnt_q     <= row_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      bird_shadow_q <= bird_shadow_d;
      pipe_shadow_q <= pipe_shadow_d;
      nz_cnt_q      <= nz_cnt_d;
      rec_row_q     <= rec_row_d;
      bird_row_q    <= bird_row_d;
      bird_valid_q  <= bird_valid_d;
      hit_q         <= hit_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    row_cnt_d     = row_cnt_q;
    dwell_cnt_d   = dwell_cnt_q + DW_ONE;
    bird_shadow_d = bird_shadow_q;
    pipe_shadow_d = pipe_shadow_q;
    nz_cnt_d      = nz_cnt_q;
    rec_row_d     = rec_row_q;
    bird_row_d    = bird_row_q;
    bird_valid_d  = bird_valid_q;
    hit_d         = hit_q;

    // Row advances when the slot wraps; the 4-bit row counter wraps 15 -> 0.
    if (dwell_cnt_q == DW_LAST) begin
      dwell_cnt_d = '0;
      row_cnt_d   = row_cnt_q + 4'd1;
    end

    // The snapshot is taken on the edge ending the first blank cycle, so the
    // whole frame (row 0 onward) shows one consistent picture.
    if (frame_start) begin
      bird_shadow_d = bus.bird_grid;
      pipe_shadow_d = bus.pipe_grid;
      nz_cnt_d      = 2'd0;
    end

    if (decode_slot && (cur_bird != 16'h0)) begin
      rec_row_d = row_cnt_q;
      if (nz_cnt_q != 2'd2) begin
        nz_cnt_d = nz_cnt_q + 2'd1;
      end
    end

    // Only a frame with exactly one lit bird row updates the decoded row;
    // otherwise the last good row is kept and flagged invalid.
    if (frame_end) begin
      bird_valid_d = (nz_cnt_q == 2'd1);
      if (nz_cnt_q == 2'd1) begin
        bird_row_d = rec_row_q;
      end
    end

    // Set takes priority over clear so a collision is never lost.
    if (decode_slot && ((cur_bird & cur_pipe) != 16'h0)) begin
      hit_d = 1'b1;
    end else if (bus.clear_hit) begin
      hit_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (registered state only)
  // --------------------------------------------------------------------------
  logic [15:0] row_sink_o;
  logic [15:0] red_driver_o;
  logic [15:0] green_driver_o;

  always_comb begin
    row_sink_o     = 16'hFFFF;
    red_driver_o   = 16'h0;
    green_driver_o = 16'h0;
    if (!blank) begin
      row_sink_o     = ~(16'h1 << row_cnt_q);
      red_driver_o   = cur_pipe;
      green_driver_o = cur_bird;
    end
  end

  assign bus.row_sink     = row_sink_o;
  assign bus.red_driver   = red_driver_o;
  assign bus.green_driver = green_driver_o;
  assign bus.frame_done   = frame_end;
  assign bus.bird_row     = bird_row_q;
  assign bus.bird_valid   = bird_valid_q;
  assign bus.hit          = hit_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
module tb_matrix_scan_driver;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_miss;

  matrix_scan_driver_if bus ();

  matrix_scan_driver #(.DWELL(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          c;
    logic [15:0] rs;
    logic [15:0] red;
    logic [15:0] grn;
    logic        fd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; sampling point is 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  // Independent expectation for a frame with one bird row and no pipes.
  task automatic check_model(input int brow, input logic [15:0] bval);
    int d;
    int r;
    logic [15:0] ers;
    logic [15:0] egr;
    d   = cyc % 4;
    r   = (cyc / 4) % 16;
    ers = (d == 0) ? 16'hFFFF : ~(16'h1 << r);
    egr = (d != 0 && r == brow) ? bval : 16'h0;
    check("scan_row_sink", bus.row_sink, ers);
    check("scan_green", bus.green_driver, egr);
    check("scan_red", bus.red_driver, 16'h0);
    check("scan_frame_done", {15'h0, bus.frame_done}, (cyc % 64 == 63) ? 16'h1 : 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_sink"},   bus.row_sink,     16'hFFFF);
    check({tag, "_red"},        bus.red_driver,   16'h0);
    check({tag, "_green"},      bus.green_driver, 16'h0);
    check({tag, "_frame_done"}, {15'h0, bus.frame_done}, 16'h0);
    check({tag, "_bird_row"},   {12'h0, bus.bird_row},   16'h0);
    check({tag, "_bird_valid"}, {15'h0, bus.bird_valid}, 16'h0);
    check({tag, "_hit"},        {15'h0, bus.hit},        16'h0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;

    //            cycle row_sink  red    green    fd
    tbl[0]  = '{0,  16'hFFFF, 16'h0, 16'h0,    1'b0};
    tbl[1]  = '{1,  16'hFFFE, 16'h0, 16'h0,    1'b0};
    tbl[2]  = '{27, 16'hFFBF, 16'h0, 16'h0,    1'b0};
    tbl[3]  = '{28, 16'hFFFF, 16'h0, 16'h0,    1'b0};
    tbl[4]  = '{29, 16'hFF7F, 16'h0, 16'h0800, 1'b0};
    tbl[5]  = '{30, 16'hFF7F, 16'h0, 16'h0800, 1'b0};
    tbl[6]  = '{31, 16'hFF7F, 16'h0, 16'h0800, 1'b0};
    tbl[7]  = '{32, 16'hFFFF, 16'h0, 16'h0,    1'b0};
    tbl[8]  = '{33, 16'hFEFF, 16'h0, 16'h0,    1'b0};
    tbl[9]  = '{62, 16'h7FFF, 16'h0, 16'h0,    1'b0};
    tbl[10] = '{63, 16'h7FFF, 16'h0, 16'h0,    1'b1};
    tbl[11] = '{64, 16'hFFFF, 16'h0, 16'h0,    1'b0};

    reset            = 1'b1;
    bus.bird_grid    = '0;
    bus.pipe_grid    = '0;
    bus.clear_hit    = 1'b0;
    bus.bird_grid[7] = 16'h0800;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Basic scan, frame 0
    for (int i = 0; i < 12; i++) begin
      goto(tbl[i].c);
      check("tbl_row_sink",   bus.row_sink,     tbl[i].rs);
      check("tbl_red",        bus.red_driver,   tbl[i].red);
      check("tbl_green",      bus.green_driver, tbl[i].grn);
      check("tbl_frame_done", {15'h0, bus.frame_done}, {15'h0, tbl[i].fd});
    end
    check("basic_bird_row",   {12'h0, bus.bird_row},   16'h7);
    check("basic_bird_valid", {15'h0, bus.bird_valid}, 16'h1);

    // Blanking and scan shape over frames 1..3
    while (cyc < 255) begin
      step();
      check_model(7, 16'h0800);
    end
    check("scan_hit", {15'h0, bus.hit}, 16'h0);

    // Collision (frame 4 snapshot)
    step();
    bus.pipe_grid[7] = 16'h0800;
    goto(285);
    check("coll_hit_before", {15'h0, bus.hit}, 16'h0);
    step();
    check("coll_hit_set", {15'h0, bus.hit}, 16'h1);
    check("coll_red", bus.red_driver, 16'h0800);
    goto(383);
    check("coll_hit_sticky", {15'h0, bus.hit}, 16'h1);

    // Overlap removed in frame 6, single-cycle clear
    step();
    bus.pipe_grid = '0;
    goto(400);
    check("clr_hit_still", {15'h0, bus.hit}, 16'h1);
    bus.clear_hit = 1'b1;
    step();
    bus.clear_hit = 1'b0;
    check("clr_hit_cleared", {15'h0, bus.hit}, 16'h0);

    // Set and clear in the same cycle: set wins
    goto(448);
    bus.pipe_grid[7] = 16'h0800;
    goto(477);
    check("setwin_before", {15'h0, bus.hit}, 16'h0);
    bus.clear_hit = 1'b1;
    step();
    bus.clear_hit = 1'b0;
    check("setwin_hit", {15'h0, bus.hit}, 16'h1);

    // Frame 8: clear, and two bird rows lit
    goto(512);
    bus.pipe_grid    = '0;
    bus.clear_hit    = 1'b1;
    bus.bird_grid    = '0;
    bus.bird_grid[2] = 16'h0001;
    bus.bird_grid[5] = 16'h8000;
    step();
    bus.clear_hit = 1'b0;
    check("clr2_hit", {15'h0, bus.hit}, 16'h0);
    goto(521);
    check("two_green_r2", bus.green_driver, 16'h0001);
    check("two_rs_r2", bus.row_sink, 16'hFFFB);
    goto(576);
    check("two_valid", {15'h0, bus.bird_valid}, 16'h0);
    check("two_row_hold", {12'h0, bus.bird_row}, 16'h7);

    // Frame 9: empty bird grid
    bus.bird_grid = '0;
    goto(640);
    check("zero_valid", {15'h0, bus.bird_valid}, 16'h0);
    check("zero_row_hold", {12'h0, bus.bird_row}, 16'h7);

    // Frame 10: bird back on row 7
    bus.bird_grid[7] = 16'h0800;
    goto(704);
    check("back_valid", {15'h0, bus.bird_valid}, 16'h1);
    check("back_row", {12'h0, bus.bird_row}, 16'h7);

    // Frame 11: move bird to row 3 while row 10 is scanning
    goto(744);
    bus.bird_grid    = '0;
    bus.bird_grid[3] = 16'h0800;
    step();
    check("tear_green_r10", bus.green_driver, 16'h0);
    goto(768);
    check("tear_row_old", {12'h0, bus.bird_row}, 16'h7);
    check("tear_valid_old", {15'h0, bus.bird_valid}, 16'h1);
    goto(781);
    check("tear_rs_r3", bus.row_sink, 16'hFFF7);
    check("tear_green_r3", bus.green_driver, 16'h0800);
    goto(797);
    check("tear_green_r7", bus.green_driver, 16'h0);
    goto(832);
    check("tear_row_new", {12'h0, bus.bird_row}, 16'h3);

    // Frame 13: overlap on row 3, then reset during row 9
    bus.pipe_grid[3] = 16'h0800;
    goto(846);
    check("rst_pre_hit", {15'h0, bus.hit}, 16'h1);
    goto(870);
    check("rst_pre_rs", bus.row_sink, 16'hFDFF);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.pipe_grid = '0;
    @(negedge clk);
    release_reset();
    check("restart_rs0", bus.row_sink, 16'hFFFF);
    step();
    check("restart_rs1", bus.row_sink, 16'hFFFE);
    goto(62);
    check("restart_fd62", {15'h0, bus.frame_done}, 16'h0);
    step();
    check("restart_fd63", {15'h0, bus.frame_done}, 16'h1);
    step();
    check("restart_row", {12'h0, bus.bird_row}, 16'h3);
    check("restart_valid", {15'h0, bus.bird_valid}, 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
